// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 7-segment scan scheduler: dead-time per slot, per-digit masking, frame-coherent capture.
// Optional brightness dimming is compiled in with `define DISP_SCAN_DIM_EN (adds the duty input).
module disp_scan_ctrl #(
    parameter int N_DIG = 2,
    parameter int DIV   = 27000,
    parameter int BLANK = 270
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [4*N_DIG-1:0]       dig_data,
    input  logic [N_DIG-1:0]         dig_mask,
`ifdef DISP_SCAN_DIM_EN
    input  logic [3:0]               duty,
`endif
    output logic [3:0]               nib,
    output logic [N_DIG-1:0]         an,
    output logic                     seg_blank,
    output logic [$clog2(N_DIG)-1:0] slot_idx,
    output logic                     frame_tick
);

    localparam int SW = $clog2(N_DIG);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
    localparam logic [SW-1:0] SLOT_LAST = SW'(N_DIG - 1);
`ifdef DISP_SCAN_DIM_EN
    localparam int WW = CW + 5;
    localparam logic [WW-1:0] DRIVE_LEN = WW'(DIV - BLANK);
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_DRIVE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SW-1:0]        slot_q, slot_d;
    logic [4*N_DIG-1:0]   snap_q, snap_d;
    logic [3:0]           nib_q, nib_d;
    logic [N_DIG-1:0]     an_q, an_d;
    logic                 seg_blank_q, seg_blank_d;
    logic                 frame_tick_q, frame_tick_d;
    logic [N_DIG-1:0]     onehot_d;
    logic                 drive_d;
    logic                 in_win_d;
`ifdef DISP_SCAN_DIM_EN
    logic [3:0]           duty_q, duty_d;
    logic [WW-1:0]        win_lhs_d, win_rhs_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            slot_q       <= '0;
            snap_q       <= '0;
            nib_q        <= '0;
            an_q         <= '0;
            seg_blank_q  <= 1'b1;
            frame_tick_q <= 1'b0;
`ifdef DISP_SCAN_DIM_EN
            duty_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            slot_q       <= slot_d;
            snap_q       <= snap_d;
            nib_q        <= nib_d;
            an_q         <= an_d;
            seg_blank_q  <= seg_blank_d;
            frame_tick_q <= frame_tick_d;
`ifdef DISP_SCAN_DIM_EN
            duty_q       <= duty_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        slot_d       = slot_q;
        snap_d       = snap_q;
        frame_tick_d = 1'b0;
        onehot_d     = '0;
        drive_d      = 1'b0;
        in_win_d     = 1'b1;
        an_d         = '0;
        seg_blank_d  = 1'b1;
        nib_d        = nib_q;

        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            slot_d  = '0;
        end else if (state_q == ST_IDLE) begin
            // Frame start from idle: fresh snapshot so nib is valid in the first blank cycle.
            cnt_d        = '0;
            slot_d       = '0;
            snap_d       = dig_data;
            frame_tick_d = 1'b1;
            state_d      = (cnt_d < CNT_BLANK) ? ST_BLANK : ST_DRIVE;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (slot_q == SLOT_LAST) begin
                slot_d       = '0;
                snap_d       = dig_data;
                frame_tick_d = 1'b1;
            end else begin
                slot_d = slot_q + SW'(1);
            end
            state_d = (cnt_d < CNT_BLANK) ? ST_BLANK : ST_DRIVE;
        end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_d < CNT_BLANK) ? ST_BLANK : ST_DRIVE;
        end

`ifdef DISP_SCAN_DIM_EN
        // Duty is latched as each slot starts so the window is stable for the whole slot.
        duty_d    = (cnt_d == '0) ? duty : duty_q;
        win_lhs_d = WW'(cnt_d - CNT_BLANK) << 4;
        win_rhs_d = (WW'(duty_d) + WW'(1)) * DRIVE_LEN;
        in_win_d  = (win_lhs_d < win_rhs_d);
`endif

        for (int k = 0; k < N_DIG; k++) begin
            if (slot_d == SW'(k)) begin
                onehot_d[k] = 1'b1;
            end
        end

        // Outputs are registered from the next-state values so they line up with state/cnt.
        drive_d     = (state_d == ST_DRIVE) && dig_mask[slot_d] && in_win_d;
        an_d        = drive_d ? onehot_d : '0;
        seg_blank_d = ~drive_d;
        if (state_d != ST_IDLE) begin
            nib_d = snap_d[{slot_d, 2'b00} +: 4];
        end
    end

    assign nib        = nib_q;
    assign an         = an_q;
    assign seg_blank  = seg_blank_q;
    assign slot_idx   = slot_q;
    assign frame_tick = frame_tick_q;

endmodule
